adder: RTL and testbench

Parameterised WIDTH-bit binary adder with selectable carry-in usage and an optional output register stage. It sits on datapaths that need a registered or combinational `a + b (+ cin)` with carry-out. The structural form is built from a ripple chain of one-bit full-adder cells generated per bit.

---
 rtl/adder.sv | 122 ++++++++++++
 tb/tb_adder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder.sv
// WIDTH-bit ripple-carry adder with optional carry-in and optional output register.
// Define ADDER_OVERFLOW_EN to add the signed-overflow output `ovf`.

module adder_full_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

module adder_half_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic co
);
    assign s  = a ^ b;
    assign co = a & b;
endmodule

module adder #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned PIPELINE_ENABLE = 1,
    parameter int unsigned USE_FULL_ADDER  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the carry out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_c;
    logic             cout_c;

    generate
        if (USE_FULL_ADDER != 0) begin : g_bit0_full
            assign carry[0] = cin;
            adder_full_cell u_cell0 (
                .a  (a[0]),
                .b  (b[0]),
                .ci (carry[0]),
                .s  (sum_c[0]),
                .co (carry[1])
            );
        end else begin : g_bit0_half
            logic unused_cin;
            assign unused_cin = cin;
            assign carry[0]   = 1'b0;
            adder_half_cell u_cell0 (
                .a  (a[0]),
                .b  (b[0]),
                .s  (sum_c[0]),
                .co (carry[1])
            );
        end

        for (genvar i = 1; i < WIDTH; i++) begin : g_ripple
            adder_full_cell u_cell (
                .a  (a[i]),
                .b  (b[i]),
                .ci (carry[i]),
                .s  (sum_c[i]),
                .co (carry[i+1])
            );
        end
    endgenerate

    assign cout_c = carry[WIDTH];

`ifdef ADDER_OVERFLOW_EN
    logic ovf_c;

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    assign ovf_c = carry[WIDTH] ^ carry[WIDTH-1];
`endif

    generate
        if (PIPELINE_ENABLE != 0) begin : g_pipe
            // All outputs captured together so they always describe one result.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sum  <= '0;
                    cout <= 1'b0;
`ifdef ADDER_OVERFLOW_EN
                    ovf  <= 1'b0;
`endif
                end else begin
                    sum  <= sum_c;
                    cout <= cout_c;
`ifdef ADDER_OVERFLOW_EN
                    ovf  <= ovf_c;
`endif
                end
            end
        end else begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign sum  = sum_c;
            assign cout = cout_c;
`ifdef ADDER_OVERFLOW_EN
            assign ovf  = ovf_c;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_adder.sv
// Directed self-checking bench for adder: pipelined full/half-adder, combinational
// and 1-bit boundary instances.

module tb_adder;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;

    logic [3:0] sum_f,  sum_h,  sum_c;
    logic       cout_f, cout_h, cout_c;
    logic [0:0] sum_1;
    logic       cout_1;
    logic       ovf_f,  ovf_h,  ovf_c,  ovf_1;

    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    adder #(.WIDTH(4), .PIPELINE_ENABLE(1), .USE_FULL_ADDER(1)) u_full (
        .clk (clk), .rst (rst), .a (a), .b (b), .cin (cin),
        .sum (sum_f), .cout (cout_f)
`ifdef ADDER_OVERFLOW_EN
        , .ovf (ovf_f)
`endif
    );

    adder #(.WIDTH(4), .PIPELINE_ENABLE(1), .USE_FULL_ADDER(0)) u_half (
        .clk (clk), .rst (rst), .a (a), .b (b), .cin (cin),
        .sum (sum_h), .cout (cout_h)
`ifdef ADDER_OVERFLOW_EN
        , .ovf (ovf_h)
`endif
    );

    adder #(.WIDTH(4), .PIPELINE_ENABLE(0), .USE_FULL_ADDER(1)) u_comb (
        .clk (clk), .rst (rst), .a (a), .b (b), .cin (cin),
        .sum (sum_c), .cout (cout_c)
`ifdef ADDER_OVERFLOW_EN
        , .ovf (ovf_c)
`endif
    );

    adder #(.WIDTH(1), .PIPELINE_ENABLE(0), .USE_FULL_ADDER(1)) u_w1 (
        .clk (clk), .rst (rst), .a (a1), .b (b1), .cin (cin1),
        .sum (sum_1), .cout (cout_1)
`ifdef ADDER_OVERFLOW_EN
        , .ovf (ovf_1)
`endif
    );

`ifndef ADDER_OVERFLOW_EN
    assign ovf_f = 1'b0;
    assign ovf_h = 1'b0;
    assign ovf_c = 1'b0;
    assign ovf_1 = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; a = 4'b1001; b = 4'b1010; cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({cout_f, sum_f, cout_h, sum_h} !== 10'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d full=%b/%h half=%b/%h want 0/0", i, cout_f, sum_f, cout_h, sum_h);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({cout_f, sum_f} !== 5'b1_0100) begin
                failures++;
                $display("FAIL release_full cyc=%0d got cout=%b sum=%b want cout=1 sum=0100", i, cout_f, sum_f);
            end
            checks++;
            if ({cout_h, sum_h} !== 5'b1_0011) begin
                failures++;
                $display("FAIL release_half cyc=%0d got cout=%b sum=%b want cout=1 sum=0011", i, cout_h, sum_h);
            end
`ifdef ADDER_OVERFLOW_EN
            checks++;
            if ({ovf_f, ovf_h} !== 2'b11) begin
                failures++;
                $display("FAIL release_ovf cyc=%0d got full=%b half=%b want 1 1", i, ovf_f, ovf_h);
            end
`endif
        end
    endtask

    task automatic test_comb();
        a = 4'hF; b = 4'h0; cin = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({cout_c, sum_c, ovf_c} !== 6'b1_0000_0) begin
                failures++;
                $display("FAIL comb_f0 step=%0d got cout=%b sum=%h ovf=%b want 1 0 0", i, cout_c, sum_c, ovf_c);
            end
            rst = ~rst;
            tick();
        end
        rst = 1'b0;
        a = 4'h5; b = 4'h6; cin = 1'b0;
        #1;
        checks++;
`ifdef ADDER_OVERFLOW_EN
        if ({cout_c, sum_c, ovf_c} !== 6'b0_1011_1) begin
`else
        if ({cout_c, sum_c} !== 5'b0_1011) begin
`endif
            failures++;
            $display("FAIL comb_56 got cout=%b sum=%h ovf=%b want 0 b 1", cout_c, sum_c, ovf_c);
        end
    endtask

    task automatic test_ovf();
        rst = 1'b0; a = 4'h7; b = 4'h1; cin = 1'b0;
        tick();
        checks++;
        if ({cout_f, sum_f, cout_h, sum_h} !== 10'b0_1000_0_1000) begin
            failures++;
            $display("FAIL ovf_sum got full=%b/%h half=%b/%h want 0/8 0/8", cout_f, sum_f, cout_h, sum_h);
        end
`ifdef ADDER_OVERFLOW_EN
        checks++;
        if ({ovf_f, ovf_h} !== 2'b11) begin
            failures++;
            $display("FAIL ovf_flag got full=%b half=%b want 1 1", ovf_f, ovf_h);
        end
`endif
        rst = 1'b1;
        tick();
        checks++;
        if ({cout_f, sum_f, ovf_f, cout_h, sum_h, ovf_h} !== 12'b0) begin
            failures++;
            $display("FAIL ovf_reset got full=%b/%h/%b half=%b/%h/%b want all 0", cout_f, sum_f, ovf_f, cout_h, sum_h, ovf_h);
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_f;
        logic [4:0] exp_h;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a   = 4'(i);
            b   = 4'(15 - i);
            cin = 1'(i & 1);
            if (i > 0) begin
                #1;
                checks++;
                if ({cout_f, sum_f} !== exp_f) begin
                    failures++;
                    $display("FAIL b2b_latency i=%0d got %b want %b", i, {cout_f, sum_f}, exp_f);
                end
            end
            exp_f = (cin == 1'b1) ? 5'b1_0000 : 5'b0_1111;
            exp_h = 5'b0_1111;
            tick();
            checks++;
            if ({cout_f, sum_f, ovf_f} !== {exp_f, 1'b0}) begin
                failures++;
                $display("FAIL b2b_full i=%0d got cout=%b sum=%h ovf=%b want %b", i, cout_f, sum_f, ovf_f, exp_f);
            end
            checks++;
            if ({cout_h, sum_h, ovf_h} !== {exp_h, 1'b0}) begin
                failures++;
                $display("FAIL b2b_half i=%0d got cout=%b sum=%h ovf=%b want %b", i, cout_h, sum_h, ovf_h, exp_h);
            end
        end
    endtask

    task automatic test_width1();
        // {a, b, cin} -> {cout, sum, ovf}
        logic [2:0] exp_tab [8];
        logic [2:0] got;
        exp_tab = '{3'b000, 3'b011, 3'b010, 3'b100, 3'b010, 3'b100, 3'b101, 3'b110};
        for (int i = 0; i < 8; i++) begin
            a1   = 1'((i >> 2) & 1);
            b1   = 1'((i >> 1) & 1);
            cin1 = 1'(i & 1);
            #1;
`ifdef ADDER_OVERFLOW_EN
            got = {cout_1, sum_1, ovf_1};
`else
            got = {cout_1, sum_1, exp_tab[i][0]};
`endif
            checks++;
            if (got !== exp_tab[i]) begin
                failures++;
                $display("FAIL width1 abc=%0d got %b want %b", i, got, exp_tab[i]);
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; a = '0; b = '0; cin = 1'b0;
        a1 = '0; b1 = '0; cin1 = 1'b0;
        test_reset();
        test_comb();
        test_ovf();
        test_back_to_back();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
